// File: rtl/rr_arb4way16_if.sv
// Handshake and data bundle between four producers, the round-robin arbiter and its consumer.
interface rr_arb4way16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       sel;
    logic [15:0]      xfer_cnt;

    // Producer/consumer side: drives source words and accepts the output.
    modport master (
        output a, b, c, d, req_valid, out_ready,
        input  req_ready, out, out_valid, sel, xfer_cnt
    );

    // Arbiter side.
    modport slave (
        input  a, b, c, d, req_valid, out_ready,
        output req_ready, out, out_valid, sel, xfer_cnt
    );
endinterface

// File: rtl/rr_arb4way16.sv
// 4-source round-robin arbiter feeding a single-entry registered output stage;
// sel uses mux4way16 encoding (00=a .. 11=d).
module rr_arb4way16 #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    rr_arb4way16_if.slave  bus
);

    logic [1:0]       last_grant_q;
    logic [1:0]       last_grant_d;
    logic [1:0]       sel_q;
    logic [1:0]       sel_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [15:0]      xfer_cnt_q;
    logic [15:0]      xfer_cnt_d;

    logic [1:0]       grant_s;
    logic [1:0]       scan_idx_s;
    logic             grant_found_s;
    logic             can_accept_s;
    logic             accept_s;
    logic             drain_s;
    logic [3:0]       req_ready_s;
    logic [WIDTH-1:0] grant_data_s;

    // Scan sources starting just after the last winner; first requester wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = 2'b00;
        scan_idx_s    = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            scan_idx_s = last_grant_q + 2'(k);
            if (!grant_found_s && bus.req_valid[scan_idx_s]) begin
                grant_found_s = 1'b1;
                grant_s       = scan_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // The slot can take a word when empty or when it drains this same cycle.
    assign can_accept_s = !out_valid_q || bus.out_ready;
    assign accept_s     = grant_found_s && can_accept_s && !reset;
    assign drain_s      = out_valid_q && bus.out_ready;

    // One-hot grant, suppressed under backpressure and during reset.
    always_comb begin
        req_ready_s = 4'b0000;
        if (accept_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = 4'b0000;
        end
    end

    // Select the winning source word.
    always_comb begin
        case (grant_s)
            2'b00:   grant_data_s = bus.a;
            2'b01:   grant_data_s = bus.b;
            2'b10:   grant_data_s = bus.c;
            2'b11:   grant_data_s = bus.d;
            default: grant_data_s = {WIDTH{1'b0}};
        endcase
    end

    // Next state of the output stage; accept takes precedence over a plain drain.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (accept_s) begin
            out_d        = grant_data_s;
            out_valid_d  = 1'b1;
            sel_d        = grant_s;
            last_grant_d = grant_s;
        end else if (drain_s) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // Handshake counter, free-running modulo 2^16.
    always_comb begin
        if (drain_s) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // State registers; last_grant resets to 3 so source 0 is scanned first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            sel_q        <= 2'b00;
            last_grant_q <= 2'b11;
            xfer_cnt_q   <= 16'd0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel       = sel_q;
    assign bus.xfer_cnt  = xfer_cnt_q;

endmodule
